// File: rtl/vmem_bus_arbiter.sv
// Video-memory bus arbiter: one pixel-fetch port and two control units share a single
// memory port, with a bounded pixel run and round-robin between the control units.
module vmem_bus_arbiter #(
    parameter int unsigned MAX_PIX_RUN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_as,
    input  logic [21:0] req_addr0,
    input  logic [21:0] req_addr1,
    input  logic [21:0] req_addr2,
    input  logic [2:0]  req_burst,
    output logic [2:0]  req_ack,
    output logic [2:0]  req_valid,
    output logic [15:0] req_din,
    output logic [21:0] mem_address,
    output logic        mem_as,
    output logic        mem_burst,
    input  logic [15:0] mem_din,
    input  logic        mem_ack,
    input  logic        mem_burstdata_valid,
    output logic [1:0]  owner,
    output logic [1:0]  state_o
);

    // Handshake: a requester holds req_as until it sees its req_ack pulse; the memory
    // returns one mem_ack per cycle and any number of mem_burstdata_valid beats before it.
    localparam int unsigned RW = $clog2(MAX_PIX_RUN + 1);
    localparam logic [RW-1:0] PIX_MAX = RW'(MAX_PIX_RUN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [21:0]   addr_q, addr_d;
    logic          burst_q, burst_d;
    logic          as_q, as_d;
    logic [RW-1:0] pix_run_q, pix_run_d;
    logic          last_unit_q, last_unit_d;

    logic ctrl_pending;
    logic unit_sel;
    logic pix_wins;

    assign ctrl_pending = req_as[1] | req_as[2];
    // On a tie the unit not served last wins; otherwise whichever unit is asking.
    assign unit_sel     = (req_as[1] & req_as[2]) ? ~last_unit_q : req_as[2];
    assign pix_wins     = req_as[0] & ~((pix_run_q == PIX_MAX) & ctrl_pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            addr_q      <= '0;
            burst_q     <= 1'b0;
            as_q        <= 1'b0;
            pix_run_q   <= '0;
            last_unit_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            as_q        <= as_d;
            pix_run_q   <= pix_run_d;
            last_unit_q <= last_unit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        as_d        = as_q;
        pix_run_d   = pix_run_q;
        last_unit_d = last_unit_q;
        case (state_q)
            IDLE: begin
                if (|req_as) begin
                    state_d = GRANT;
                    as_d    = 1'b1;
                    if (pix_wins) begin
                        owner_d = 2'd1;
                        addr_d  = req_addr0;
                        burst_d = req_burst[0];
                        // The run only counts while a control unit is actually waiting.
                        if (!ctrl_pending) begin
                            pix_run_d = '0;
                        end else if (pix_run_q != PIX_MAX) begin
                            pix_run_d = pix_run_q + RW'(1);
                        end
                    end else if (!unit_sel) begin
                        owner_d     = 2'd2;
                        addr_d      = req_addr1;
                        burst_d     = req_burst[1];
                        last_unit_d = 1'b0;
                        pix_run_d   = '0;
                    end else begin
                        owner_d     = 2'd3;
                        addr_d      = req_addr2;
                        burst_d     = req_burst[2];
                        last_unit_d = 1'b1;
                        pix_run_d   = '0;
                    end
                end
            end
            GRANT: begin
                if (mem_ack) begin
                    state_d = RELEASE;
                    as_d    = 1'b0;
                    owner_d = 2'd0;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                as_d    = 1'b0;
                owner_d = 2'd0;
            end
        endcase
    end

    // Memory responses are steered to the owner only while a cycle is in flight.
    always_comb begin
        req_ack   = 3'b000;
        req_valid = 3'b000;
        if (state_q == GRANT) begin
            case (owner_q)
                2'd1: begin
                    req_ack[0]   = mem_ack;
                    req_valid[0] = mem_burstdata_valid;
                end
                2'd2: begin
                    req_ack[1]   = mem_ack;
                    req_valid[1] = mem_burstdata_valid;
                end
                2'd3: begin
                    req_ack[2]   = mem_ack;
                    req_valid[2] = mem_burstdata_valid;
                end
                default: ;
            endcase
        end
    end

    assign req_din     = mem_din;
    assign mem_address = addr_q;
    assign mem_as      = as_q;
    assign mem_burst   = burst_q;
    assign owner       = owner_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_vmem_bus_arbiter.sv
// Directed bench for vmem_bus_arbiter: grant latency, priority/round-robin sequences,
// burst data steering, reset mid-cycle and stray memory responses.
module tb_vmem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_as;
    logic [21:0] req_addr0, req_addr1, req_addr2;
    logic [2:0]  req_burst;
    logic [2:0]  req_ack;
    logic [2:0]  req_valid;
    logic [15:0] req_din;
    logic [21:0] mem_address;
    logic        mem_as;
    logic        mem_burst;
    logic [15:0] mem_din;
    logic        mem_ack;
    logic        mem_burstdata_valid;
    logic [1:0]  owner;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    vmem_bus_arbiter #(.MAX_PIX_RUN(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_as              (req_as),
        .req_addr0           (req_addr0),
        .req_addr1           (req_addr1),
        .req_addr2           (req_addr2),
        .req_burst           (req_burst),
        .req_ack             (req_ack),
        .req_valid           (req_valid),
        .req_din             (req_din),
        .mem_address         (mem_address),
        .mem_as              (mem_as),
        .mem_burst           (mem_burst),
        .mem_din             (mem_din),
        .mem_ack             (mem_ack),
        .mem_burstdata_valid (mem_burstdata_valid),
        .owner               (owner),
        .state_o             (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output logic [1:0] own);
        int n = 0;
        while (!mem_as && n < 20) begin
            step();
            n++;
        end
        if (!mem_as) check("grant_timeout", 32'd0, 32'd1);
        own = owner;
    endtask

    // Acknowledge the current cycle and step into RELEASE.
    task automatic serve(input logic [2:0] exp_ack);
        mem_ack = 1'b1;
        #1;
        check("serve_ack", req_ack, exp_ack);
        step();
        mem_ack = 1'b0;
        check("rel_mem_as", mem_as, 1'b0);
        check("rel_owner", owner, 2'd0);
    endtask

    initial begin
        logic [1:0]  own;
        logic        vpat [6];
        int          beats;
        logic [15:0] beat_data;

        reset = 1'b1; req_as = '0; req_burst = '0;
        req_addr0 = '0; req_addr1 = '0; req_addr2 = '0;
        mem_din = '0; mem_ack = 1'b0; mem_burstdata_valid = 1'b0;
        do_reset();

        check("rst_mem_as", mem_as, 1'b0);
        check("rst_owner", owner, 2'd0);
        check("rst_addr", mem_address, 22'd0);
        check("rst_burst", mem_burst, 1'b0);
        check("rst_ack", req_ack, 3'b000);
        check("rst_valid", req_valid, 3'b000);
        check("rst_state", state_o, 2'd0);

        // Single unit-0 read; requester drops as before the ack, which still reaches it.
        req_as = 3'b010; req_addr1 = 22'h000400;
        step();
        check("u0_mem_as", mem_as, 1'b1);
        check("u0_addr", mem_address, 22'h000400);
        check("u0_owner", owner, 2'd2);
        req_as = 3'b000;
        step();
        check("u0_addr_hold", mem_address, 22'h000400);
        serve(3'b010);
        check("u0_state_rel", state_o, 2'd2);
        step();
        check("u0_state_idle", state_o, 2'd0);

        // Both control units held: strict alternation starting with unit 0.
        do_reset();
        req_addr2 = 22'h000800;
        req_as = 3'b110;
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        for (int i = 0; i < 4; i++) begin
            wait_grant(own);
            check("rr_owner", own, exp_q.pop_front());
            serve(own == 2'd2 ? 3'b010 : 3'b100);
        end
        req_as = 3'b000;
        step();

        // Pixel + unit 0 held: four pixel grants, then unit 0 breaks in.
        do_reset();
        req_as = 3'b011;
        exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        for (int i = 0; i < 6; i++) begin
            wait_grant(own);
            check("pix_owner", own, exp_q.pop_front());
            serve(own == 2'd1 ? 3'b001 : 3'b010);
        end
        req_as = 3'b000;
        step();

        // Unit 0 burst with four data beats and one gap cycle.
        req_as = 3'b010; req_burst = 3'b010; req_addr1 = 22'h001234;
        wait_grant(own);
        check("bst_owner", own, 2'd2);
        check("bst_burst", mem_burst, 1'b1);
        check("bst_addr", mem_address, 22'h001234);
        req_as = 3'b000;
        vpat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            mem_burstdata_valid = vpat[i];
            beat_data = 16'h1111 * 16'(beats + 1);
            mem_din = vpat[i] ? beat_data : 16'hDEAD;
            #1;
            check("bst_valid", req_valid, vpat[i] ? 3'b010 : 3'b000);
            check("bst_din", req_din, vpat[i] ? beat_data : 16'hDEAD);
            if (vpat[i]) beats++;
            step();
        end
        mem_burstdata_valid = 1'b0;
        serve(3'b010);
        mem_burstdata_valid = 1'b1;
        #1;
        check("rel_valid_ignored", req_valid, 3'b000);
        mem_burstdata_valid = 1'b0;
        req_burst = 3'b000;
        step();

        // Reset lands while the ack is pending.
        req_as = 3'b100; req_addr2 = 22'h3FFFFF;
        wait_grant(own);
        check("rg_owner", own, 2'd3);
        req_as = 3'b000;
        mem_ack = 1'b1; reset = 1'b1;
        step();
        check("rg_mem_as", mem_as, 1'b0);
        check("rg_owner_rst", owner, 2'd0);
        check("rg_ack", req_ack, 3'b000);
        reset = 1'b0;
        step();
        check("rg_ack_after", req_ack, 3'b000);
        mem_ack = 1'b0;
        req_as = 3'b001; req_addr0 = 22'h2AAAAA;
        wait_grant(own);
        check("rg_next_owner", own, 2'd1);
        check("rg_next_addr", mem_address, 22'h2AAAAA);
        req_as = 3'b000;
        serve(3'b001);
        step();

        // Stray ack while idle.
        mem_ack = 1'b1;
        #1;
        check("stray_ack", req_ack, 3'b000);
        step();
        check("stray_state", state_o, 2'd0);
        check("stray_mem_as", mem_as, 1'b0);
        mem_ack = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vmem_bus_arbiter.md
VMEM_BUS_ARBITER -- requirements
Module: vmem_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_PIX_RUN, default 4, max consecutive pixel-fetch grants while a control requester waits.
REQ-002 SHALL have port: clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req_as  in  3  per-requester address strobe; bit0 pixel fetch, bit1 control unit 0, bit2 control unit 1.
REQ-005 SHALL have ports: req_addr0, req_addr1, req_addr2  in  22 each  requester word address.
REQ-006 SHALL have port: req_burst  in  3  per-requester burst request.
REQ-007 SHALL have port: req_ack  out  3  per-requester bus_ack, one-hot or zero.
REQ-008 SHALL have port: req_valid  out  3  per-requester burstdata_valid, one-hot or zero.
REQ-009 SHALL have port: req_din  out  16  memory read data, broadcast to all requesters.
REQ-010 SHALL have ports: mem_address  out  22; mem_as  out  1; mem_burst  out  1.
REQ-011 SHALL have ports: mem_din  in  16; mem_ack  in  1; mem_burstdata_valid  in  1.
REQ-012 SHALL have port: owner  out  2  current grant: 0 none, 1 pixel, 2 unit0, 3 unit1.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-014 IDLE: if any req_as bit set, SHALL select winner, latch its address/burst into mem_address/mem_burst, set mem_as=1, set owner, enter GRANT; mem_as asserts the cycle after the request is sampled (1-cycle latency).
REQ-015 Priority SHALL be: pixel fetch first, unless pix_run counter == MAX_PIX_RUN and a control bit is set.
REQ-016 Among units 0/1 SHALL be round-robin: on simultaneous requests, grant the unit not served last; last_unit resets to 1 (unit 0 wins first tie).
REQ-017 pix_run SHALL increment on each pixel grant, saturate at MAX_PIX_RUN, and clear on any control grant or when no control request is pending at a pixel grant.
REQ-018 GRANT: req_valid[owner] SHALL equal mem_burstdata_valid combinationally; all other req_valid bits 0.
REQ-019 GRANT: req_ack[owner] SHALL equal mem_ack combinationally; all other req_ack bits 0.
REQ-020 req_din SHALL equal mem_din at all times.
REQ-021 GRANT: on mem_ack SHALL deassert mem_as next cycle and enter RELEASE; address SHALL stay stable throughout GRANT.
REQ-022 RELEASE: one cycle, owner=0, mem_as=0, then IDLE; a requester keeping as high across its ack is treated as a new request arbitrated in IDLE.
REQ-023 Owner dropping req_as before mem_ack SHALL NOT abort the memory cycle; arbiter waits for mem_ack and discards it (req_ack still pulses to owner).
REQ-024 Requests arriving during GRANT/RELEASE SHALL be held by requester, not queued internally.
REQ-025 mem_burstdata_valid or mem_ack outside GRANT SHALL be ignored; req_valid/req_ack stay 0.

Reset
REQ-026 On reset SHALL go IDLE; mem_as=0, mem_burst=0, mem_address=0, owner=0, req_ack=0, req_valid=0, pix_run=0, last_unit=1.
REQ-027 Reset mid-GRANT SHALL drop mem_as the following cycle; no ack forwarded after reset.

Verification
REQ-028 req_as=3'b010, req_addr1=0x000400 -> mem_as=1, mem_address=0x000400, owner=2 next cycle; mem_ack -> req_ack=3'b010, mem_as=0 next cycle.
REQ-029 req_as=3'b110 held continuously through 4 transactions -> owner sequence 2,3,2,3.
REQ-030 req_as=3'b011 held, MAX_PIX_RUN=4 -> owner sequence 1,1,1,1,2,1,...
REQ-031 Unit 0 burst, 4 mem_burstdata_valid pulses data 0x1111..0x4444 -> req_valid=3'b010 on exactly those 4 cycles, req_din matches, req_valid[0],[2] stay 0.
REQ-032 Reset asserted mid-GRANT with pending mem_ack -> mem_as=0, owner=0, req_ack=0 after reset; next request granted normally.
REQ-033 Stray mem_ack in IDLE -> all req_ack remain 0, state unchanged.
